// File: rtl/lcd_bus_arbiter.sv
// Two-port round-robin arbiter for the HD44780 write bus. It latches the granted byte, then
// generates the setup / enable / hold / execution-wait timing and acks the requester.
module lcd_bus_arbiter #(
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_EN       = 12,
  parameter int unsigned T_HOLD     = 2,
  parameter int unsigned T_WAIT     = 2000,
  parameter int unsigned T_CLR_WAIT = 80000
) (
  input  logic       clk,
  input  logic       s_rst_n,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] dat0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] dat1,
  output logic       ack1,
  output logic       busy,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic       on,
  output logic [7:0] data
);

  localparam int unsigned MaxA = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int unsigned MaxB = (T_HOLD > T_WAIT) ? T_HOLD : T_WAIT;
  localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxT = (MaxC > T_CLR_WAIT) ? MaxC : T_CLR_WAIT;
  localparam int unsigned CntW = $clog2(MaxT + 1);

  localparam logic [CntW-1:0] LdSetup = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] LdEn    = CntW'(T_EN - 1);
  localparam logic [CntW-1:0] LdHold  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] LdWait  = CntW'(T_WAIT - 1);
  localparam logic [CntW-1:0] LdClr   = CntW'(T_CLR_WAIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnHi,
    StHold,
    StWait,
    StAck,
    StGap
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_last;   // 1: port 1 was granted last
  logic            r_port;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_en;
  logic            r_on;
  logic            r_busy;
  logic            r_ack0;
  logic            r_ack1;
  logic            w_grant;
  logic            w_pick1;
  logic            w_is_clr;
  logic            w_cnt_zero;

  always_comb begin
    w_pick1    = req1 & (~req0 | ~r_last);
    w_is_clr   = ~r_rs & (r_data[7:2] == 6'd0) & (r_data[1:0] != 2'd0);
    w_cnt_zero = (r_cnt == '0);
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_grant    = 1'b0;
    case (r_state)
      // GAP itself is the no-sample cycle after ACK; the decision at its closing edge
      // is the same as IDLE's, so back-to-back grants land two cycles after ack.
      StIdle, StGap: begin
        if (req0 | req1) begin
          w_grant   = 1'b1;
          w_state_d = StSetup;
          w_cnt_d   = LdSetup;
        end else begin
          w_state_d = StIdle;
        end
      end
      StSetup: begin
        if (w_cnt_zero) begin
          w_state_d = StEnHi;
          w_cnt_d   = LdEn;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StEnHi: begin
        if (w_cnt_zero) begin
          w_state_d = StHold;
          w_cnt_d   = LdHold;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StHold: begin
        if (w_cnt_zero) begin
          w_state_d = StWait;
          w_cnt_d   = w_is_clr ? LdClr : LdWait;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StWait: begin
        if (w_cnt_zero) begin
          w_state_d = StAck;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StAck:   w_state_d = StGap;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they change exactly with the state.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_en    <= 1'b0;
      r_on    <= 1'b0;
      r_busy  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_on    <= 1'b1;
      r_en    <= (w_state_d == StEnHi);
      r_busy  <= (w_state_d != StIdle);
      r_ack0  <= (w_state_d == StAck) & ~r_port;
      r_ack1  <= (w_state_d == StAck) & r_port;
      if (w_grant) begin
        r_port <= w_pick1;
        r_last <= w_pick1;
        r_rs   <= w_pick1 ? rs1 : rs0;
        r_data <= w_pick1 ? dat1 : dat0;
      end
    end
  end

  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign busy = r_busy;
  assign rs   = r_rs;
  assign rw   = 1'b0;
  assign en   = r_en;
  assign on   = r_on;
  assign data = r_data;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter with shortened wait parameters.
// Stimulus pushes expected acks / enable windows; a negedge monitor pops and compares.
module tb_lcd_bus_arbiter;

  // T_SETUP=2, T_EN=12, T_HOLD=2, T_WAIT=50, T_CLR_WAIT=300
  localparam int LatN   = 66;   // 2+12+2+50
  localparam int LatC   = 316;  // 2+12+2+300
  localparam int Period = 68;   // LatN + ACK + GAP

  logic       clk;
  logic       s_rst_n;
  logic       req0, rs0, ack0, req1, rs1, ack1;
  logic [7:0] dat0, dat1, data;
  logic       busy, rs, rw, en, on;

  lcd_bus_arbiter #(
    .T_SETUP   (2),
    .T_EN      (12),
    .T_HOLD    (2),
    .T_WAIT    (50),
    .T_CLR_WAIT(300)
  ) u_dut (
    .clk    (clk),
    .s_rst_n(s_rst_n),
    .req0   (req0),
    .rs0    (rs0),
    .dat0   (dat0),
    .ack0   (ack0),
    .req1   (req1),
    .rs1    (rs1),
    .dat1   (dat1),
    .ack1   (ack1),
    .busy   (busy),
    .rs     (rs),
    .rw     (rw),
    .en     (en),
    .on     (on),
    .data   (data)
  );

  typedef struct {
    logic       port;
    logic       rs;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  typedef struct {
    int rise;
    int fall;
  } en_t;

  exp_t ack_q[$];
  en_t  en_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input logic p, input logic r, input logic [7:0] d, input int lat,
                       output int g);
    if (p) begin
      req1 = 1'b1; rs1 = r; dat1 = d;
    end else begin
      req0 = 1'b1; rs0 = r; dat0 = d;
    end
    g = cyc + 1;
    ack_q.push_back('{port: p, rs: r, dat: d, cyc: g + lat});
    en_q.push_back('{rise: g + 2, fall: g + 14});
  endtask

  // Monitor
  initial begin
    logic en_prev;
    int   rise;
    exp_t e;
    en_t  w;
    en_prev = 1'b0;
    rise    = 0;
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        en_prev = 1'b0;
      end else begin
        if (ack0 || ack1) begin
          if (ack_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)",
                     ack0, ack1, cyc);
          end else begin
            e = ack_q.pop_front();
            chk("ack_onehot", int'(ack0) + int'(ack1), 1);
            chk("ack_port", int'(ack1), int'(e.port));
            chk("ack_cycle", cyc, e.cyc);
            chk("ack_rs", int'(rs), int'(e.rs));
            chk("ack_data", int'(data), int'(e.dat));
          end
        end
        if (en && !en_prev) rise = cyc;
        if (!en && en_prev) begin
          if (en_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_en: got pulse %0d..%0d expected none", rise, cyc);
          end else begin
            w = en_q.pop_front();
            chk("en_rise", rise, w.rise);
            chk("en_fall", cyc, w.fall);
          end
        end
        en_prev = en;
      end
    end
  end

  // Stimulus
  initial begin
    int         g;
    int         g0;
    logic       vr[6];
    logic [7:0] vd[6];
    int         vl[6];
    vr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vd = '{8'h01, 8'h38, 8'h02, 8'h00, 8'h01, 8'h03};
    vl = '{LatC, LatN, LatC, LatN, LatN, LatC};

    s_rst_n = 1'b0;
    req0 = 1'b0; rs0 = 1'b0; dat0 = 8'h00;
    req1 = 1'b0; rs1 = 1'b0; dat1 = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rs", int'(rs), 0);
    chk("rst_rw", int'(rw), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_on", int'(on), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_ack1", int'(ack1), 0);
    chk("rst_busy", int'(busy), 0);
    s_rst_n = 1'b1;
    @(negedge clk);
    chk("on_after_release", int'(on), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_en", int'(en), 0);
    repeat (2) @(negedge clk);

    // Single data write on port 0
    issue(1'b0, 1'b1, 8'h41, LatN, g);
    @(negedge clk);
    chk("grant_rs", int'(rs), 1);
    chk("grant_data", int'(data), 'h41);
    chk("grant_busy", int'(busy), 1);
    chk("grant_rw", int'(rw), 0);
    wait_until(g + LatN);
    req0 = 1'b0;
    wait_until(g + LatN + 2);
    chk("busy_after_ack", int'(busy), 0);

    // Clear/home vs ordinary wait selection
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, vr[i], vd[i], vl[i], g);
      wait_until(g + vl[i]);
      req0 = 1'b0;
      wait_until(g + vl[i] + 2);
    end

    // Both ports requesting continuously after reset
    s_rst_n = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b1;
    @(negedge clk);
    rs0 = 1'b0; dat0 = 8'h38; rs1 = 1'b1; dat1 = 8'h30;
    req0 = 1'b1; req1 = 1'b1;
    g0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      ack_q.push_back('{port: logic'(k % 2), rs: logic'(k % 2),
                        dat: (k % 2 == 1) ? 8'h30 : 8'h38, cyc: g0 + k * Period + LatN});
      en_q.push_back('{rise: g0 + k * Period + 2, fall: g0 + k * Period + 14});
    end
    wait_until(g0 + 3 * Period);
    req0 = 1'b0; req1 = 1'b0;
    wait_until(g0 + 3 * Period + LatN + 2);
    chk("rr_busy_end", int'(busy), 0);

    // Port 1 drops req after grant and changes its byte
    issue(1'b1, 1'b1, 8'h55, LatN, g);
    @(negedge clk);
    req1 = 1'b0; dat1 = 8'hFF;
    @(negedge clk);
    chk("drop_data_held", int'(data), 'h55);
    wait_until(g + LatN + 10);
    chk("drop_no_second", int'(busy), 0);

    // Reset during EN_HI, then a fresh tie goes to port 0
    req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h42;
    g = cyc + 1;
    wait_until(g + 5);
    chk("abort_en_high", int'(en), 1);
    s_rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("abort_en", int'(en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_data", int'(data), 0);
    chk("abort_on", int'(on), 0);
    repeat (3) @(negedge clk);
    s_rst_n = 1'b1;
    @(negedge clk);
    req1 = 1'b1; rs1 = 1'b0; dat1 = 8'h38;
    issue(1'b0, 1'b1, 8'h43, LatN, g);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    wait_until(g + 2 * LatN);
    chk("post_abort_busy", int'(busy), 0);

    chk("ack_q_empty", ack_q.size(), 0);
    chk("en_q_empty", en_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single LCD1602 (HD44780-style) write bus between two character/command requesters and generates all bus timing. It sits between the LCD content logic and the `rs/rw/en/on/data` pins:
- Port 0 is the init/command sequencer.
- Port 1 is the time/alarm display refresh.

Each write is latched on grant, driven with setup, enable-pulse and hold timing, and followed by the controller execution wait. The requester gets a one-cycle acknowledge when the write completes.

## Interface
Parameters:
- T_SETUP, 2: cycles `rs/data` are stable before `en` rises (≥1)
- T_EN, 12: cycles `en` is high (≥1)
- T_HOLD, 2: cycles `rs/data` are held after `en` falls (≥1)
- T_WAIT, 2000: execution wait for ordinary writes (≥1)
- T_CLR_WAIT, 80000: execution wait for clear/home commands (≥ T_WAIT)

Ports:
- clk  in  1  system clock
- s_rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  port 0 write request (level)
- rs0  in  1  port 0 register select (0 = command, 1 = data)
- dat0  in  8  port 0 byte
- ack0  out  1  port 0 write complete, one-cycle pulse
- req1, rs1, dat1, ack1: same as port 0, for port 1
- busy  out  1  transfer in progress (grant through GAP)
- rs  out  1  LCD register select
- rw  out  1  LCD read/write, constant 0
- en  out  1  LCD enable strobe
- on  out  1  LCD power/backlight enable
- data  out  8  LCD data bus

## Operation
- FSM states: IDLE → SETUP → EN_HI → HOLD → WAIT → ACK → GAP → IDLE.
- IDLE: requests are sampled only in this state.
  - If any `req` is high, grant one port, latch its `rs`/`dat` into the `rs`/`data` output registers, record the granted port, and go to SETUP.
- Arbitration is two-way round-robin.
  - If both ports request, grant the port not granted last.
  - The last-granted pointer resets to port 1, so port 0 wins the first tie.
  - A single requester is always granted.
- SETUP lasts T_SETUP cycles; EN_HI lasts T_EN cycles with `en` = 1; HOLD lasts T_HOLD cycles.
- WAIT lasts T_CLR_WAIT cycles for a clear/home command, otherwise T_WAIT cycles.
  - Clear/home means latched `rs` = 0, `data[7:2]` = 0 and `data` ≠ 0 (0x01, 0x02, 0x03).
  - Command 0x00 uses T_WAIT.
- ACK (1 cycle): pulse the granted port's `ack`; the other port's `ack` stays 0.
- GAP (1 cycle): no sampling. This lets a registered requester drop `req` after seeing `ack`.
- A granted transfer is committed. Dropping `req` after grant does not abort it, and `ack` still pulses.
- `rs`/`data` stay stable from grant until the next grant; they are never changed during SETUP..GAP.
- Use a single down-counter of width clog2(max parameter + 1), reloaded on each state entry.
- `rw` is tied to 0. `on` resets to 0 and goes to 1 on the first clock after reset release, then stays 1.

## Timing
- Reset values:
  - `rs` = 0, `rw` = 0, `en` = 0, `on` = 0, `data` = 0x00
  - `ack0` = `ack1` = 0, `busy` = 0
  - state = IDLE, last-granted pointer = port 1
- Reset asserted mid-transfer: all outputs return to reset values immediately (`en` falls asynchronously).
  - The interrupted transfer is discarded and never acked.
- Cycle timing, with the grant at clock edge G:
  - `busy` = 1 from G.
  - `en` rises at G + T_SETUP and falls at G + T_SETUP + T_EN.
  - `ack` is high for the cycle starting at G + T_SETUP + T_EN + T_HOLD + Twait, where Twait = T_WAIT or T_CLR_WAIT.
  - `busy` falls 2 cycles after `ack` rises.
  - The earliest next grant is also 2 cycles after `ack` rises.
- Defaults: ordinary write `ack` at G + 2016; clear `ack` at G + 80016.
- Back-to-back throughput with both ports requesting: one write per T_SETUP + T_EN + T_HOLD + Twait + 2 cycles, alternating ports.

## Test plan
- Reset: hold `s_rst_n` = 0 → all outputs 0. Release → `on` = 1 after 1 cycle; `busy` = 0 and `en` = 0 with no request.
- Single write, port 0 with `rs0` = 1, `dat0` = 0x41:
  - `rs` = 1 and `data` = 0x41 from G; `en` high for exactly 12 cycles starting G + 2.
  - `ack0` one cycle at G + 2016; `ack1` never pulses.
- Both ports request continuously after reset (port 0 = 0x38 command, port 1 = 0x30 data):
  - Grant order is 0, 1, 0, 1.
  - Each `ack` corresponds to the correct latched byte; grants are spaced 2018 cycles apart.
- Clear command `rs0` = 0, `dat0` = 0x01 → `ack0` at G + 80016. Command 0x38 → `ack0` at G + 2016. Command 0x02 → G + 80016.
- `req1` dropped one cycle after grant with `dat1` changed to 0xFF:
  - `data` stays at the latched byte and `ack1` still pulses.
  - No second transfer starts.
- Reset asserted during EN_HI:
  - `en` is 0 immediately and no `ack`.
  - After release, a fresh `req0` completes normally with port 0 winning the tie.
